idecode_pipe: RTL and testbench

Parametrised, pipelined successor to the single-cycle LEGv8 decode stage. It contains a 2-read/1-write register file with XZR semantics and optional write-through bypass. It also extracts instruction fields, classifies the instruction format and produces a sign-extended immediate. Results are registered behind a valid/ready handshake, between fetch (IF/ID) and execute (ID/EX).

---
 rtl/idecode_pipe_pkg.sv | 57 +++++
 rtl/idecode_pipe_if.sv | 37 +++
 rtl/idecode_pipe_reg_file.sv | 54 +++++
 rtl/idecode_pipe.sv | 117 +++++++++++
 tb/tb_idecode_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/idecode_pipe_pkg.sv
// Shared definitions for the LEGv8 decode stage: instruction format encoding,
// opcode match constants, field bit positions and the format classifier.
package idecode_pipe_pkg;

   typedef enum logic [2:0] {
      FMT_R  = 3'd0,
      FMT_I  = 3'd1,
      FMT_D  = 3'd2,
      FMT_B  = 3'd3,
      FMT_CB = 3'd4
   } fmt_e;

   // Register 31 reads as zero and ignores writes.
   localparam logic [4:0] XZR_IDX = 5'd31;

   // Field positions inside the 32-bit LEGv8 instruction word.
   localparam int OPC_LSB   = 21;
   localparam int OPC_W     = 11;
   localparam int RM_LSB    = 16;
   localparam int RN_LSB    = 5;
   localparam int RD_LSB    = 0;
   localparam int REG_W     = 5;
   localparam int DIMM_LSB  = 12;
   localparam int DIMM_W    = 9;
   localparam int CBIMM_LSB = 5;
   localparam int CBIMM_W   = 19;
   localparam int BIMM_LSB  = 0;
   localparam int BIMM_W    = 26;
   localparam int IIMM_LSB  = 10;
   localparam int IIMM_W    = 12;

   // Opcode match values; each is compared against the top bits of the opcode.
   localparam logic [10:0] OPC_STUR  = 11'h7C0;
   localparam logic [10:0] OPC_LDUR  = 11'h7C2;
   localparam logic [7:0]  OPC_CBZ   = 8'hB4;
   localparam logic [7:0]  OPC_CBNZ  = 8'hB5;
   localparam logic [5:0]  OPC_B     = 6'h05;
   localparam logic [9:0]  OPC_ADDI  = 10'h244;
   localparam logic [9:0]  OPC_ADDIS = 10'h2C4;
   localparam logic [9:0]  OPC_SUBI  = 10'h344;
   localparam logic [9:0]  OPC_SUBIS = 10'h3C4;

   // Classify the opcode; the check order resolves overlapping encodings.
   function automatic fmt_e decode_fmt(input logic [10:0] opc);
      if (opc == OPC_STUR || opc == OPC_LDUR)
         return FMT_D;
      if (opc[10:3] == OPC_CBZ || opc[10:3] == OPC_CBNZ)
         return FMT_CB;
      if (opc[10:5] == OPC_B)
         return FMT_B;
      if (opc[10:1] == OPC_ADDI || opc[10:1] == OPC_ADDIS ||
          opc[10:1] == OPC_SUBI || opc[10:1] == OPC_SUBIS)
         return FMT_I;
      return FMT_R;
   endfunction

endpackage

// File: rtl/idecode_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
// slave: the decode stage itself; master: whoever drives fetch and sinks execute.
interface idecode_pipe_if #(
   parameter int unsigned DATA_W  = 64,
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned PC_W    = 64
);
   logic               in_valid;
   logic               in_ready;
   logic [INSTR_W-1:0] in_instr;
   logic [PC_W-1:0]    in_npc;
   logic               in_reg2loc;

   logic               out_valid;
   logic               out_ready;
   logic [PC_W-1:0]    out_npc;
   logic [10:0]        out_opcode;
   logic [4:0]         out_rn;
   logic [4:0]         out_rm;
   logic [4:0]         out_rd;
   logic [DATA_W-1:0]  out_rdata1;
   logic [DATA_W-1:0]  out_rdata2;
   logic [DATA_W-1:0]  out_imm;
   logic [2:0]         out_fmt;

   modport slave (
      input  in_valid, in_instr, in_npc, in_reg2loc, out_ready,
      output in_ready, out_valid, out_npc, out_opcode, out_rn, out_rm, out_rd,
             out_rdata1, out_rdata2, out_imm, out_fmt
   );

   modport master (
      output in_valid, in_instr, in_npc, in_reg2loc, out_ready,
      input  in_ready, out_valid, out_npc, out_opcode, out_rn, out_rm, out_rd,
             out_rdata1, out_rdata2, out_imm, out_fmt
   );
endinterface

// File: rtl/idecode_pipe_reg_file.sv
// 2-read/1-write register file with XZR semantics and out-of-range zeroing.
// Optional write-through bypass when IDECODE_BYPASS_EN is defined.
module reg_file_2r1w
   import idecode_pipe_pkg::*;
#(
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned DATA_W   = 64
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              we,
   input  logic [4:0]        waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [4:0]        raddr1,
   input  logic [4:0]        raddr2,
   output logic [DATA_W-1:0] rdata1,
   output logic [DATA_W-1:0] rdata2
);
   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              wr_ok;

   assign wr_ok = we && (waddr != XZR_IDX) && (32'(waddr) < NUM_REGS);

   function automatic logic [DATA_W-1:0] read_port(input logic [4:0] addr);
      if (addr == XZR_IDX || 32'(addr) >= NUM_REGS)
         return '0;
`ifdef IDECODE_BYPASS_EN
      if (wr_ok && waddr == addr)
         return wdata;
`endif
      return regs[addr[AW-1:0]];
   endfunction

   // Register array: cleared on reset, otherwise written when the write is legal.
   // NOTE: the array is reset because reset must clear architectural state; this
   // keeps it in flops rather than an inferred RAM, which is acceptable at 32 entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (wr_ok) begin
         regs[waddr[AW-1:0]] <= wdata;
      end
   end

   // Combinational read ports.
   always_comb begin
      rdata1 = read_port(raddr1);
      rdata2 = read_port(raddr2);
   end

endmodule

// File: rtl/idecode_pipe.sv
// Pipelined LEGv8 decode stage between IF/ID and ID/EX with valid/ready handshake.
// Optional feature: define IDECODE_BYPASS_EN for register-file write-through.
module idecode_pipe
   import idecode_pipe_pkg::*;
#(
   parameter int unsigned DATA_W   = 64,
   parameter int unsigned INSTR_W  = 32,
   parameter int unsigned NUM_REGS = 32,
   parameter int unsigned PC_W     = 64
) (
   input  logic              clk,
   input  logic              reset,
   idecode_pipe_if.slave     bus,
   input  logic              flush,
   input  logic              wb_en,
   input  logic [4:0]        wb_addr,
   input  logic [DATA_W-1:0] wb_data
);
   logic [INSTR_W-1:0] instr;
   logic [10:0]        opcode;
   logic [4:0]         rn, rm, rd, rsel2;
   fmt_e               fmt;
   logic [DATA_W-1:0]  imm;
   logic [DATA_W-1:0]  rf_rdata1, rf_rdata2;
   logic               capture;

   logic               out_valid_q;
   logic [PC_W-1:0]    out_npc_q;
   logic [10:0]        out_opcode_q;
   logic [4:0]         out_rn_q, out_rm_q, out_rd_q;
   logic [DATA_W-1:0]  out_rdata1_q, out_rdata2_q, out_imm_q;
   fmt_e               out_fmt_q;

   assign instr   = bus.in_instr;
   assign opcode  = instr[OPC_LSB +: OPC_W];
   assign rn      = instr[RN_LSB +: REG_W];
   assign rm      = instr[RM_LSB +: REG_W];
   assign rd      = instr[RD_LSB +: REG_W];
   assign rsel2   = bus.in_reg2loc ? rd : rm;

   assign bus.in_ready = !out_valid_q || bus.out_ready;
   assign capture      = bus.in_valid && bus.in_ready && !flush;

   reg_file_2r1w #(
      .NUM_REGS (NUM_REGS),
      .DATA_W   (DATA_W)
   ) u_rf (
      .clk    (clk),
      .reset  (reset),
      .we     (wb_en),
      .waddr  (wb_addr),
      .wdata  (wb_data),
      .raddr1 (rn),
      .raddr2 (rsel2),
      .rdata1 (rf_rdata1),
      .rdata2 (rf_rdata2)
   );

   // Format classification and immediate extension.
   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      fmt = decode_fmt(opcode);
      imm = '0;
      case (fmt)
         FMT_D:   imm = {{(DATA_W-DIMM_W){instr[DIMM_LSB+DIMM_W-1]}}, instr[DIMM_LSB +: DIMM_W]};
         FMT_CB:  imm = {{(DATA_W-CBIMM_W){instr[CBIMM_LSB+CBIMM_W-1]}}, instr[CBIMM_LSB +: CBIMM_W]};
         FMT_B:   imm = {{(DATA_W-BIMM_W){instr[BIMM_LSB+BIMM_W-1]}}, instr[BIMM_LSB +: BIMM_W]};
         FMT_I:   imm = {{(DATA_W-IIMM_W){1'b0}}, instr[IIMM_LSB +: IIMM_W]};
         default: imm = '0;
      endcase
   end

   // Output register: flush kills, capture loads, consumption without new input empties.
   // NOTE: non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_npc_q    <= '0;
         out_opcode_q <= '0;
         out_rn_q     <= '0;
         out_rm_q     <= '0;
         out_rd_q     <= '0;
         out_rdata1_q <= '0;
         out_rdata2_q <= '0;
         out_imm_q    <= '0;
         out_fmt_q    <= FMT_R;
      end else if (flush) begin
         out_valid_q  <= 1'b0;
      end else if (capture) begin
         out_valid_q  <= 1'b1;
         out_npc_q    <= bus.in_npc;
         out_opcode_q <= opcode;
         out_rn_q     <= rn;
         out_rm_q     <= rm;
         out_rd_q     <= rd;
         out_rdata1_q <= rf_rdata1;
         out_rdata2_q <= rf_rdata2;
         out_imm_q    <= imm;
         out_fmt_q    <= fmt;
      end else if (bus.out_ready) begin
         out_valid_q  <= 1'b0;
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.out_npc    = out_npc_q;
   assign bus.out_opcode = out_opcode_q;
   assign bus.out_rn     = out_rn_q;
   assign bus.out_rm     = out_rm_q;
   assign bus.out_rd     = out_rd_q;
   assign bus.out_rdata1 = out_rdata1_q;
   assign bus.out_rdata2 = out_rdata2_q;
   assign bus.out_imm    = out_imm_q;
   assign bus.out_fmt    = out_fmt_q;

endmodule

// File: tb/tb_idecode_pipe.sv
// Self-checking bench for idecode_pipe: table-driven decode vectors through a
// scoreboard, plus hand-written hold, flush, bypass and reset sequences.
module tb_idecode_pipe;

   typedef struct {
      logic [31:0] instr;
      logic        reg2loc;
      logic [2:0]  fmt;
      logic [63:0] imm;
   } vec_t;

   typedef struct {
      logic [31:0] instr;
      logic [63:0] npc;
      logic [10:0] opcode;
      logic [4:0]  rn, rm, rd;
      logic [63:0] rd1, rd2, imm;
      logic [2:0]  fmt;
   } exp_t;

   logic        clk;
   logic        reset;
   logic        flush;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [63:0] wb_data;

   idecode_pipe_if #(.DATA_W(64), .INSTR_W(32), .PC_W(64)) bus ();
   idecode_pipe_if #(.DATA_W(64), .INSTR_W(32), .PC_W(64)) bus16 ();

   idecode_pipe #(.DATA_W(64), .INSTR_W(32), .NUM_REGS(32), .PC_W(64)) dut (
      .clk(clk), .reset(reset), .bus(bus), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   // Second instance with 16 registers sees the same stimulus.
   idecode_pipe #(.DATA_W(64), .INSTR_W(32), .NUM_REGS(16), .PC_W(64)) dut16 (
      .clk(clk), .reset(reset), .bus(bus16), .flush(flush),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
   );

   assign bus16.in_valid   = bus.in_valid;
   assign bus16.in_instr   = bus.in_instr;
   assign bus16.in_npc     = bus.in_npc;
   assign bus16.in_reg2loc = bus.in_reg2loc;
   assign bus16.out_ready  = bus.out_ready;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_total = 0;
   int          n_bad   = 0;
   int          n_pushed = 0;
   int          n_popped = 0;
   logic        last_accept;
   logic [63:0] model [32];
   exp_t        sb [$];
   logic [2:0]  cur_fmt;
   logic [63:0] cur_imm;
   vec_t        vecs [11];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   function automatic logic [63:0] exp_read(input logic [4:0] idx);
      if (idx == 5'd31) return '0;
`ifdef IDECODE_BYPASS_EN
      if (wb_en && wb_addr == idx) return wb_data;
`endif
      return model[idx];
   endfunction

   task automatic compare(input exp_t e);
      string t;
      t = $sformatf("%h", e.instr);
      check({"npc@", t},    bus.out_npc,    e.npc);
      check({"opcode@", t}, 64'(bus.out_opcode), 64'(e.opcode));
      check({"rn@", t},     64'(bus.out_rn), 64'(e.rn));
      check({"rm@", t},     64'(bus.out_rm), 64'(e.rm));
      check({"rd@", t},     64'(bus.out_rd), 64'(e.rd));
      check({"rdata1@", t}, bus.out_rdata1, e.rd1);
      check({"rdata2@", t}, bus.out_rdata2, e.rd2);
      check({"imm@", t},    bus.out_imm,    e.imm);
      check({"fmt@", t},    64'(bus.out_fmt), 64'(e.fmt));
   endtask

   // One clock: consume/produce scoreboard entries at mid-cycle, then cross the edge.
   task automatic step();
      exp_t       e;
      logic [4:0] sel2;
      @(negedge clk);
      last_accept = 1'b0;
      if (reset) begin
         sb.delete();
         foreach (model[i]) model[i] = '0;
      end else begin
         if (bus.out_valid && flush) begin
            if (sb.size() > 0) e = sb.pop_front();
         end else if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL sb_unexpected: got out_valid=1 with nothing pending, required none");
            end else begin
               e = sb.pop_front();
               n_popped++;
               compare(e);
            end
         end
         if (bus.in_valid && bus.in_ready && !flush) begin
            e.instr  = bus.in_instr;
            e.npc    = bus.in_npc;
            e.opcode = e.instr[31:21];
            e.rn     = e.instr[9:5];
            e.rm     = e.instr[20:16];
            e.rd     = e.instr[4:0];
            sel2     = bus.in_reg2loc ? e.rd : e.rm;
            e.rd1    = exp_read(e.rn);
            e.rd2    = exp_read(sel2);
            e.imm    = cur_imm;
            e.fmt    = cur_fmt;
            sb.push_back(e);
            n_pushed++;
            last_accept = 1'b1;
         end
         if (wb_en && wb_addr != 5'd31) model[wb_addr] = wb_data;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [31:0] instr, input logic r2l, input logic [2:0] fmt,
                        input logic [63:0] imm, input logic [63:0] npc);
      bus.in_valid   = 1'b1;
      bus.in_instr   = instr;
      bus.in_reg2loc = r2l;
      bus.in_npc     = npc;
      cur_fmt        = fmt;
      cur_imm        = imm;
   endtask

   task automatic idle_in();
      bus.in_valid = 1'b0;
   endtask

   task automatic wb(input logic [4:0] addr, input logic [63:0] data);
      wb_en = 1'b1; wb_addr = addr; wb_data = data;
      step();
      wb_en = 1'b0;
   endtask

   task automatic drain();
      bus.out_ready = 1'b1;
      idle_in();
      for (int k = 0; k < 20 && (sb.size() != 0 || bus.out_valid); k++) step();
      check("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   initial begin
      vecs[0]  = '{32'h8B0500A1, 1'b0, 3'd0, 64'h0};
      vecs[1]  = '{32'hF85F8062, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8};
      vecs[2]  = '{32'hF80FF041, 1'b1, 3'd2, 64'h0000_0000_0000_00FF};
      vecs[3]  = '{32'h912AF0A4, 1'b0, 3'd1, 64'h0000_0000_0000_0ABC};
      vecs[4]  = '{32'hB1200022, 1'b0, 3'd1, 64'h0000_0000_0000_0800};
      vecs[5]  = '{32'hF1000469, 1'b0, 3'd1, 64'h1};
      vecs[6]  = '{32'h17FFFFFF, 1'b0, 3'd3, 64'hFFFF_FFFF_FFFF_FFFF};
      vecs[7]  = '{32'h14000010, 1'b0, 3'd3, 64'h10};
      vecs[8]  = '{32'hB4FFFFC6, 1'b1, 3'd4, 64'hFFFF_FFFF_FFFF_FFFE};
      vecs[9]  = '{32'hB5000068, 1'b1, 3'd4, 64'h3};
      vecs[10] = '{32'hCB0A0128, 1'b0, 3'd0, 64'h0};

      reset = 1'b1; flush = 1'b0; wb_en = 1'b0; wb_addr = '0; wb_data = '0;
      bus.in_valid = 1'b0; bus.in_instr = '0; bus.in_npc = '0; bus.in_reg2loc = 1'b0;
      bus.out_ready = 1'b1;
      cur_fmt = '0; cur_imm = '0;
      step(); step();
      reset = 1'b0;

      // Reset state.
      check("rst_out_valid", 64'(bus.out_valid), 64'd0);
      check("rst_in_ready",  64'(bus.in_ready), 64'd1);
      check("rst_rdata1",    bus.out_rdata1, 64'd0);
      check("rst_rdata2",    bus.out_rdata2, 64'd0);
      check("rst_imm",       bus.out_imm, 64'd0);
      check("rst_npc",       bus.out_npc, 64'd0);
      check("rst_opcode",    64'(bus.out_opcode), 64'd0);
      check("rst_fmt",       64'(bus.out_fmt), 64'd0);

      // ADD X1,X5,X5 with X5=0x1234: one-cycle latency.
      wb(5'd5, 64'h1234);
      drive(32'h8B0500A1, 1'b0, 3'd0, 64'h0, 64'h1004);
      step();
      idle_in();
      check("add_latency_valid", 64'(bus.out_valid), 64'd1);
      check("add_rdata1", bus.out_rdata1, 64'h1234);
      step();

      // LDUR X2,[X3,#-8] with X3=0x100.
      wb(5'd3, 64'h100);
      drive(32'hF85F8062, 1'b1, 3'd2, 64'hFFFF_FFFF_FFFF_FFF8, 64'h1008);
      step();
      idle_in();
      check("ldur_rdata1", bus.out_rdata1, 64'h100);
      drain();

      // Preload registers (X7 left at zero for the bypass sequence).
      for (int i = 1; i <= 10; i++)
         if (i != 7) wb(5'(i), 64'hA5A5_0000_0000_0000 + 64'(i));

      // Table vectors back to back at full throughput.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].instr, vecs[i].reg2loc, vecs[i].fmt, vecs[i].imm, 64'h4000 + 64'(4 * i));
         step();
         check($sformatf("stream_accept[%0d]", i), 64'(last_accept), 64'd1);
      end
      drain();

      // Same vectors under random backpressure.
      for (int i = 0; i < 11; i++) begin
         drive(vecs[i].instr, vecs[i].reg2loc, vecs[i].fmt, vecs[i].imm, 64'h5000 + 64'(4 * i));
         for (int g = 0; g < 50; g++) begin
            bus.out_ready = 1'($urandom_range(0, 1));
            step();
            if (last_accept) break;
         end
      end
      drain();

      // XZR: writes to X31 are dropped and reads return zero.
      wb(5'd31, 64'hDEAD);
      drive(32'h8B1F03E1, 1'b0, 3'd0, 64'h0, 64'h6000);
      step();
      idle_in();
      check("xzr_rdata1", bus.out_rdata1, 64'd0);
      drain();

      // X20 exists with 32 registers, reads zero with 16.
      wb(5'd20, 64'h2020);
      drive(32'h8B140281, 1'b0, 3'd0, 64'h0, 64'h6004);
      step();
      idle_in();
      check("nr16_valid",   64'(bus16.out_valid), 64'd1);
      check("nr16_rdata1",  bus16.out_rdata1, 64'd0);
      check("nr32_rdata1",  bus.out_rdata1, 64'h2020);
      drain();

      // Same-cycle writeback of X7 with a decode reading X7.
      wb_en = 1'b1; wb_addr = 5'd7; wb_data = 64'h55;
      drive(32'h8B0700E1, 1'b0, 3'd0, 64'h0, 64'h7000);
      step();
      wb_en = 1'b0;
      idle_in();
`ifdef IDECODE_BYPASS_EN
      check("bypass_rdata1", bus.out_rdata1, 64'h55);
`else
      check("bypass_rdata1", bus.out_rdata1, 64'h0);
`endif
      drive(32'h8B0700E1, 1'b0, 3'd0, 64'h0, 64'h7004);
      step();
      idle_in();
      check("after_wb_rdata1", bus.out_rdata1, 64'h55);
      drain();

      // Hold: out_ready low for 3 cycles, writeback to X5 must not refresh held data.
      wb(5'd5, 64'h1234);
      n_pushed = 0; n_popped = 0;
      bus.out_ready = 1'b0;
      drive(32'h8B0500A1, 1'b0, 3'd0, 64'h0, 64'h2000);
      step();
      drive(32'hCB0A0128, 1'b0, 3'd0, 64'h0, 64'h2004);
      for (int c = 0; c < 3; c++) begin
         wb_en = (c == 1); wb_addr = 5'd5; wb_data = 64'h9999;
         step();
         check($sformatf("hold_in_ready[%0d]", c), 64'(bus.in_ready), 64'd0);
         check($sformatf("hold_valid[%0d]", c), 64'(bus.out_valid), 64'd1);
         check($sformatf("hold_rdata1[%0d]", c), bus.out_rdata1, 64'h1234);
         check($sformatf("hold_npc[%0d]", c), bus.out_npc, 64'h2000);
      end
      wb_en = 1'b0;
      bus.out_ready = 1'b1;
      step();
      idle_in();
      check("release_npc", bus.out_npc, 64'h2004);
      drain();
      check("hold_no_loss", 64'(n_popped), 64'(n_pushed));
      check("hold_count", 64'(n_pushed), 64'd2);

      // Flush together with in_valid: instruction dropped.
      flush = 1'b1;
      drive(32'h8B0500A1, 1'b0, 3'd0, 64'h0, 64'h3000);
      step();
      flush = 1'b0;
      idle_in();
      check("flush_valid", 64'(bus.out_valid), 64'd0);
      check("flush_sb", 64'(sb.size()), 64'd0);

      // Reset during a hold; a write in the reset cycle is ignored.
      bus.out_ready = 1'b0;
      drive(32'h8B0500A1, 1'b0, 3'd0, 64'h0, 64'h3004);
      step();
      idle_in();
      step();
      reset = 1'b1;
      wb_en = 1'b1; wb_addr = 5'd9; wb_data = 64'h77;
      step();
      reset = 1'b0;
      wb_en = 1'b0;
      check("rst_hold_valid",  64'(bus.out_valid), 64'd0);
      check("rst_hold_rdata1", bus.out_rdata1, 64'd0);
      check("rst_hold_npc",    bus.out_npc, 64'd0);
      bus.out_ready = 1'b1;
      drive(32'h8B0900A1, 1'b0, 3'd0, 64'h0, 64'h3008);
      step();
      idle_in();
      check("rst_rf_x5", bus.out_rdata1, 64'd0);
      check("rst_rf_x9", bus.out_rdata2, 64'd0);
      drain();

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
